// File: rtl/icache_fetch_if.sv
// icache_fetch_if: fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache view; master is the pipeline/memory view.
interface icache_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc_i;
    logic                  flush_i;
    logic [DATA_WIDTH-1:0] instr_o;
    logic                  stall_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    modport slave (
        input  pc_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_o, stall_o, mem_req_o, mem_addr_o
    );
    modport master (
        output pc_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_o, stall_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only instruction cache with line refill FSM.
// Optional ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_fetch #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic clk,
    input  logic rst_n,
    icache_fetch_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TB = ADDR_WIDTH - 2 - WB - IB;

    typedef enum logic [1:0] {LOOKUP, REQ, REFILL} state_t;

    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WB-1:0]         cnt_q, cnt_d;
    logic                  flush_q, flush_d;
    logic [TB-1:0]         tag_q [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES*WORDS_PER_LINE];

    logic [TB-1:0] pc_tag;
    logic [IB-1:0] pc_idx, rf_idx;
    logic [WB-1:0] pc_word;
    logic          hit, beat, last_beat, fl, unused_ok;

    assign pc_word   = bus.pc_i[2 +: WB];
    assign pc_idx    = bus.pc_i[2+WB +: IB];
    assign pc_tag    = bus.pc_i[ADDR_WIDTH-1 -: TB];
    assign rf_idx    = addr_q[2+WB +: IB];
    assign unused_ok = &{1'b0, bus.pc_i[1:0]};

    assign hit       = state_q == LOOKUP && valid_q[pc_idx] && tag_q[pc_idx] == pc_tag;
    assign beat      = state_q == REFILL && bus.mem_rvalid_i;
    assign last_beat = beat && cnt_q == WB'(WORDS_PER_LINE - 1);
    assign fl        = flush_q || bus.flush_i;

    // Gating with rst_n keeps stall low while reset is asserted.
    assign bus.instr_o    = hit ? data_q[{pc_idx, pc_word}] : '0;
    assign bus.stall_o    = rst_n && !hit;
    assign bus.mem_req_o  = state_q == REQ;
    assign bus.mem_addr_o = addr_q;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        flush_d = flush_q || (state_q != LOOKUP && bus.flush_i);
        if (state_q == LOOKUP) begin
            if (!hit) begin
                addr_d  = {bus.pc_i[ADDR_WIDTH-1:2+WB], {(WB+2){1'b0}}};
                state_d = REQ;
            end
            if (bus.flush_i) valid_d = '0;
        end else if (state_q == REQ) begin
            if (bus.mem_gnt_i) begin
                state_d         = REFILL;
                cnt_d           = '0;
                valid_d[rf_idx] = 1'b0;
            end
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
            if (last_beat) begin
                state_d = LOOKUP;
                flush_d = 1'b0;
                if (fl) valid_d = '0;
                else valid_d[rf_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOOKUP;
            valid_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) data_q[{rf_idx, cnt_q}] <= bus.mem_rdata_i;
        if (last_beat) tag_q[rf_idx] <= addr_q[ADDR_WIDTH-1 -: TB];
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (state_q == LOOKUP && !hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif
endmodule
